// File: rtl/rtc_bus_responder_if.sv
// Strobe and interrupt side of the RTC chip bus. The shared A_D_Bus stays a plain inout
// on the chip so its tristate resolves at the pin rather than inside an interface.
interface rtc_bus_responder_if;
  logic CS;
  logic RD;
  logic WR;
  logic AD;
  logic IRQ;

  modport master (output CS, RD, WR, AD, input IRQ);
  modport slave  (input CS, RD, WR, AD, output IRQ);
endinterface

// File: rtl/rtc_bus_responder.sv
// Responder model of the external RTC chip: BCD time/date, BCD countdown timer with a
// level IRQ, shadow registers committed by the 0xF0/0xF1 address commands.
module rtc_bus_responder #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  rtc_bus_responder_if.slave bus,
  inout  wire  [7:0]         A_D_Bus
);
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PresLast = PW'(TICKS_PER_SEC - 1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last,
                                         input logic [7:0] first);
    if (v >= last)           return first;
    else if (v[3:0] >= 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00)          return top;
    else if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                     return {v[7:4], v[3:0] - 4'h1};
  endfunction

  logic          cs_q, rd_q, wr_q, wr_prev_q, ad_q;
  logic [7:0]    bus_q, addr_q;
  logic [7:0]    sh_sec_q, sh_min_q, sh_hr_q, sh_day_q, sh_mon_q, sh_yr_q;
  logic [7:0]    sh_tsec_q, sh_tmin_q, sh_thr_q;
  logic [7:0]    sec_q, min_q, hr_q, day_q, mon_q, yr_q;
  logic [7:0]    tsec_q, tmin_q, thr_q;
  logic          run_q, irq_q, oe_q;
  logic [7:0]    rd_data_q;
  logic [PW-1:0] presc_q;

  logic       commit, addr_commit, data_commit, load_clk, load_tmr, tick, read_en;
  logic       irq_clr, tmr_step, expire;
  logic       c_sec, c_min, c_hr, c_day, c_mon;
  logic [7:0] tsec_nx, tmin_nx, thr_nx, rd_mux;

  always_comb begin
    commit      = wr_q & ~wr_prev_q & ~cs_q;
    addr_commit = commit & ~ad_q;
    data_commit = commit & ad_q;
    load_clk    = addr_commit & (bus_q == 8'hF0);
    load_tmr    = addr_commit & (bus_q == 8'hF1);
    tick        = (presc_q == PresLast);
    read_en     = ~cs_q & ~rd_q & ad_q;
    irq_clr     = data_commit & (addr_q == 8'h00) & bus_q[0];
    c_sec       = sec_q >= 8'h59;
    c_min       = c_sec & (min_q >= 8'h59);
    c_hr        = c_min & (hr_q >= 8'h23);
    c_day       = c_hr & (day_q >= 8'h31);
    c_mon       = c_day & (mon_q >= 8'h12);
    // Timer borrows ripple seconds -> minutes -> hours.
    tsec_nx     = bcd_dec(tsec_q, 8'h59);
    tmin_nx     = (tsec_q == 8'h00) ? bcd_dec(tmin_q, 8'h59) : tmin_q;
    thr_nx      = (tsec_q == 8'h00 && tmin_q == 8'h00) ? bcd_dec(thr_q, 8'h99) : thr_q;
    tmr_step    = run_q & tick & ~load_tmr;
    expire      = tmr_step & ({thr_nx, tmin_nx, tsec_nx} == 24'h0);
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr_q)
      8'h00:   rd_mux = {6'b0, run_q, irq_q};
      8'h21:   rd_mux = sec_q;
      8'h22:   rd_mux = min_q;
      8'h23:   rd_mux = hr_q;
      8'h24:   rd_mux = day_q;
      8'h25:   rd_mux = mon_q;
      8'h26:   rd_mux = yr_q;
      8'h41:   rd_mux = tsec_q;
      8'h42:   rd_mux = tmin_q;
      8'h43:   rd_mux = thr_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      wr_prev_q <= 1'b1;
      ad_q      <= 1'b0;
      bus_q     <= 8'h00;
    end else begin
      cs_q      <= bus.CS;
      rd_q      <= bus.RD;
      wr_q      <= bus.WR;
      wr_prev_q <= wr_q;
      ad_q      <= bus.AD;
      bus_q     <= A_D_Bus;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      addr_q    <= 8'h00;
      sh_sec_q  <= 8'h00;
      sh_min_q  <= 8'h00;
      sh_hr_q   <= 8'h00;
      sh_day_q  <= 8'h00;
      sh_mon_q  <= 8'h00;
      sh_yr_q   <= 8'h00;
      sh_tsec_q <= 8'h00;
      sh_tmin_q <= 8'h00;
      sh_thr_q  <= 8'h00;
    end else begin
      if (addr_commit) addr_q <= bus_q;
      if (data_commit) begin
        case (addr_q)
          8'h21:   sh_sec_q  <= bus_q;
          8'h22:   sh_min_q  <= bus_q;
          8'h23:   sh_hr_q   <= bus_q;
          8'h24:   sh_day_q  <= bus_q;
          8'h25:   sh_mon_q  <= bus_q;
          8'h26:   sh_yr_q   <= bus_q;
          8'h41:   sh_tsec_q <= bus_q;
          8'h42:   sh_tmin_q <= bus_q;
          8'h43:   sh_thr_q  <= bus_q;
          default: ;
        endcase
      end
    end
  end

  // A clock commit restarts the second so the loaded time is held for a full tick.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc_q <= '0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= 8'h00;
      day_q   <= 8'h01;
      mon_q   <= 8'h01;
      yr_q    <= 8'h00;
    end else if (load_clk) begin
      presc_q <= '0;
      sec_q   <= sh_sec_q;
      min_q   <= sh_min_q;
      hr_q    <= sh_hr_q;
      day_q   <= sh_day_q;
      mon_q   <= sh_mon_q;
      yr_q    <= sh_yr_q;
    end else if (tick) begin
      presc_q <= '0;
      sec_q   <= bcd_inc(sec_q, 8'h59, 8'h00);
      if (c_sec) min_q <= bcd_inc(min_q, 8'h59, 8'h00);
      if (c_min) hr_q  <= bcd_inc(hr_q, 8'h23, 8'h00);
      if (c_hr)  day_q <= bcd_inc(day_q, 8'h31, 8'h01);
      if (c_day) mon_q <= bcd_inc(mon_q, 8'h12, 8'h01);
      if (c_mon) yr_q  <= bcd_inc(yr_q, 8'h99, 8'h00);
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      tsec_q <= 8'h00;
      tmin_q <= 8'h00;
      thr_q  <= 8'h00;
      run_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (load_tmr) begin
        tsec_q <= sh_tsec_q;
        tmin_q <= sh_tmin_q;
        thr_q  <= sh_thr_q;
        run_q  <= |{sh_thr_q, sh_tmin_q, sh_tsec_q};
      end else if (tmr_step) begin
        tsec_q <= tsec_nx;
        tmin_q <= tmin_nx;
        thr_q  <= thr_nx;
        if (expire) run_q <= 1'b0;
      end
      // Expiry beats a simultaneous clear.
      if (expire)       irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      oe_q      <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      oe_q      <= read_en;
      rd_data_q <= rd_mux;
    end
  end

  assign A_D_Bus = oe_q ? rd_data_q : 8'hzz;
  assign bus.IRQ = irq_q;
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder: one-second tick every 10 clocks; a pulled-up bus
// reads 0xFF whenever nobody drives it.
module tb_rtc_bus_responder;
  localparam int unsigned Ticks = 10;
  localparam longint TickT = 100;  // 10 clocks of period 10

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tb_oe = 1'b0;
  logic [7:0] tb_dout = 8'h00;
  wire  [7:0] ad_bus;

  rtc_bus_responder_if bus_if ();

  assign ad_bus = tb_oe ? tb_dout : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (ad_bus[i]);
  end

  rtc_bus_responder #(.TICKS_PER_SEC(Ticks)) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .bus     (bus_if),
    .A_D_Bus (ad_bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  longint     f0_t = 0;
  longint     f1_t = 0;
  longint     last_commit = 0;
  logic [7:0] exp_q[$];

  // Tick edges sit at f0_t + k*TickT; count those strictly inside (from_t, cap_t).
  function automatic int ticks_in(input longint from_t, input longint cap_t);
    return int'((cap_t - 1 - f0_t) / TickT - (from_t - f0_t) / TickT);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic bus_write(input logic ad, input logic [7:0] data);
    @(negedge clk);
    bus_if.CS = 1'b0; bus_if.AD = ad; tb_dout = data; tb_oe = 1'b1; bus_if.WR = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.WR = 1'b1;
    repeat (2) @(posedge clk);
    last_commit = $time;
    @(negedge clk);
    bus_if.CS = 1'b1; bus_if.AD = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic read_begin(input logic [7:0] addr, output longint cap_t);
    bus_write(1'b0, addr);
    @(negedge clk);
    bus_if.CS = 1'b0; bus_if.AD = 1'b1; bus_if.RD = 1'b0;
    cap_t = $time + 15;
  endtask

  task automatic read_end(output logic [7:0] d);
    repeat (2) @(negedge clk);
    d = ad_bus;
    bus_if.RD = 1'b1; bus_if.CS = 1'b1; bus_if.AD = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    longint cap; logic [7:0] got, exp;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    f0_t = $time;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus_if.IRQ !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq got %b want 0", bus_if.IRQ);
    end
    n_checks++;
    if (ad_bus !== 8'hFF) begin
      n_fail++; $display("FAIL reset_bus_released got %h want ff", ad_bus);
    end
    read_begin(8'h24, cap); exp_q.push_back(8'h01); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_day got %h want %h", got, exp); end
    read_begin(8'h21, cap); exp_q.push_back(to_bcd(ticks_in(f0_t, cap) % 60));
    read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_sec got %h want %h", got, exp); end
  endtask

  task automatic test_rollover();
    logic [7:0] a[6]; logic [7:0] v[6]; logic [7:0] e[6];
    longint cap; logic [7:0] got, exp;
    a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    v = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};
    e = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    for (int i = 0; i < 6; i++) begin
      bus_write(1'b0, a[i]); bus_write(1'b1, v[i]);
    end
    bus_write(1'b0, 8'hF0);
    f0_t = last_commit;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      read_begin(a[i], cap);
      // Seconds keep ticking after the wrap; the rest stays put for under a minute.
      exp_q.push_back(i == 0 ? to_bcd((59 + ticks_in(f0_t, cap)) % 60) : e[i]);
      read_end(got); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rollover_%h got %h want %h", a[i], got, exp);
      end
    end
  endtask

  task automatic test_shadow_isolation();
    longint cap; logic [7:0] got, exp;
    bus_write(1'b0, 8'h21); bus_write(1'b1, 8'h30);
    read_begin(8'h21, cap); exp_q.push_back(to_bcd((59 + ticks_in(f0_t, cap)) % 60));
    read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL shadow_hidden got %h want %h", got, exp); end
    bus_write(1'b0, 8'hF0);
    f0_t = last_commit;
    read_begin(8'h21, cap); exp_q.push_back(to_bcd((30 + ticks_in(f0_t, cap)) % 60));
    read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL shadow_loaded got %h want %h", got, exp); end
    read_begin(8'h22, cap); exp_q.push_back(8'h59); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL shadow_min got %h want %h", got, exp); end
  endtask

  task automatic test_timer();
    longint cap, exp_t, rise_t; logic [7:0] got, exp;
    bus_write(1'b0, 8'h41); bus_write(1'b1, 8'h03);
    bus_write(1'b0, 8'h42); bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h43); bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'hF1);
    f1_t = last_commit;
    exp_t = f0_t + TickT * ((f1_t - f0_t) / TickT + 3);
    rise_t = 0;
    for (int i = 0; i < 60 && rise_t == 0; i++) begin
      @(posedge clk); #1;
      if (bus_if.IRQ === 1'b1) rise_t = $time - 1;
    end
    n_checks++;
    if (rise_t != exp_t) begin
      n_fail++; $display("FAIL timer_irq_edge got t=%0d want t=%0d", rise_t, exp_t);
    end
    read_begin(8'h00, cap); exp_q.push_back(8'h01); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL timer_status got %h want %h", got, exp); end
    bus_write(1'b0, 8'h00);
    bus_write(1'b1, 8'h01);
    n_checks++;
    if (bus_if.IRQ !== 1'b0) begin
      n_fail++; $display("FAIL timer_irq_clear got %b want 0", bus_if.IRQ);
    end
  endtask

  task automatic test_borrow();
    longint cap; int left; logic [7:0] got, exp;
    bus_write(1'b0, 8'h41); bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'h42); bus_write(1'b1, 8'h01);
    bus_write(1'b0, 8'h43); bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'hF1);
    f1_t = last_commit;
    repeat (10) @(negedge clk);
    read_begin(8'h41, cap);
    left = 60 - ticks_in(f1_t, cap);
    exp_q.push_back(to_bcd(left % 60)); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL borrow_tsec got %h want %h", got, exp); end
    read_begin(8'h42, cap);
    left = 60 - ticks_in(f1_t, cap);
    exp_q.push_back(to_bcd(left / 60)); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL borrow_tmin got %h want %h", got, exp); end
    read_begin(8'h00, cap); exp_q.push_back(8'h02); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL running_status got %h want %h", got, exp); end
  endtask

  task automatic test_collision();
    longint exp_t;
    bus_write(1'b0, 8'h41); bus_write(1'b1, 8'h03);
    bus_write(1'b0, 8'h42); bus_write(1'b1, 8'h00);
    bus_write(1'b0, 8'hF1);
    f1_t = last_commit;
    exp_t = f0_t + TickT * ((f1_t - f0_t) / TickT + 3);
    bus_write(1'b0, 8'h00);
    @(negedge clk);
    bus_if.CS = 1'b0; bus_if.AD = 1'b1; tb_dout = 8'h01; tb_oe = 1'b1; bus_if.WR = 1'b0;
    while ($time < exp_t - 15) @(negedge clk);
    bus_if.WR = 1'b1;  // clear commits on the expiry edge
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.IRQ !== 1'b1) begin
      n_fail++; $display("FAIL collision_irq got %b want 1", bus_if.IRQ);
    end
    @(negedge clk);
    bus_if.CS = 1'b1; bus_if.AD = 1'b0; tb_oe = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus_if.IRQ !== 1'b1) begin
      n_fail++; $display("FAIL collision_irq_hold got %b want 1", bus_if.IRQ);
    end
  endtask

  task automatic test_turnaround();
    bus_write(1'b0, 8'h00);
    @(negedge clk);
    bus_if.CS = 1'b0; bus_if.AD = 1'b1; bus_if.RD = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'hFF) begin n_fail++; $display("FAIL turn_early got %h want ff", ad_bus); end
    @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'h01) begin n_fail++; $display("FAIL turn_drive got %h want 01", ad_bus); end
    bus_if.RD = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'h01) begin n_fail++; $display("FAIL turn_hold got %h want 01", ad_bus); end
    @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'hFF) begin n_fail++; $display("FAIL turn_release got %h want ff", ad_bus); end
    bus_if.AD = 1'b0; bus_if.RD = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'hFF) begin n_fail++; $display("FAIL turn_addr_phase got %h want ff", ad_bus); end
    bus_if.RD = 1'b1; bus_if.AD = 1'b1; bus_if.WR = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'hFF) begin n_fail++; $display("FAIL turn_write_phase got %h want ff", ad_bus); end
    bus_if.CS = 1'b1;
    @(negedge clk);
    bus_if.WR = 1'b1; bus_if.AD = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midread();
    longint cap; logic [7:0] got, exp;
    read_begin(8'h00, cap);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ad_bus !== 8'h01) begin n_fail++; $display("FAIL midread_drive got %h want 01", ad_bus); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ad_bus !== 8'hFF) begin n_fail++; $display("FAIL midreset_bus got %h want ff", ad_bus); end
    n_checks++;
    if (bus_if.IRQ !== 1'b0) begin
      n_fail++; $display("FAIL midreset_irq got %b want 0", bus_if.IRQ);
    end
    bus_if.CS = 1'b1; bus_if.RD = 1'b1; bus_if.AD = 1'b0;
    repeat (2) @(posedge clk);
    f0_t = $time;
    @(negedge clk);
    rst_n = 1'b1;
    read_begin(8'h25, cap); exp_q.push_back(8'h01); read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL midreset_month got %h want %h", got, exp); end
    read_begin(8'h21, cap); exp_q.push_back(to_bcd(ticks_in(f0_t, cap) % 60));
    read_end(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL midreset_sec got %h want %h", got, exp); end
  endtask

  initial begin
    bus_if.CS = 1'b1; bus_if.RD = 1'b1; bus_if.WR = 1'b1; bus_if.AD = 1'b0;
    test_reset();
    test_rollover();
    test_shadow_isolation();
    test_timer();
    test_borrow();
    test_collision();
    test_turnaround();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
